// File: rtl/y2r_pkg.sv
// Shared constants and types for the YUV-to-RGB parameter scheduler.
// Holds the address map, shift limits, reset values and the scheduler FSM state.
package y2r_pkg;

    localparam logic [3:0] Y2R_ADDR_M00   = 4'd0;
    localparam logic [3:0] Y2R_ADDR_M01   = 4'd1;
    localparam logic [3:0] Y2R_ADDR_M02   = 4'd2;
    localparam logic [3:0] Y2R_ADDR_M10   = 4'd3;
    localparam logic [3:0] Y2R_ADDR_M11   = 4'd4;
    localparam logic [3:0] Y2R_ADDR_M12   = 4'd5;
    localparam logic [3:0] Y2R_ADDR_M20   = 4'd6;
    localparam logic [3:0] Y2R_ADDR_M21   = 4'd7;
    localparam logic [3:0] Y2R_ADDR_M22   = 4'd8;
    localparam logic [3:0] Y2R_ADDR_OFF0  = 4'd9;
    localparam logic [3:0] Y2R_ADDR_OFF1  = 4'd10;
    localparam logic [3:0] Y2R_ADDR_OFF2  = 4'd11;
    localparam logic [3:0] Y2R_ADDR_SHIFT = 4'd12;

    localparam logic [4:0] Y2R_SHIFT_MIN = 5'd8;
    localparam logic [4:0] Y2R_SHIFT_MAX = 5'd17;
    localparam logic [4:0] Y2R_SHIFT_RST = 5'd8;
    localparam logic [7:0] Y2R_ROUND_RST = 8'd2;

    typedef enum logic {
        Y2R_IDLE = 1'b0,
        Y2R_PEND = 1'b1
    } y2r_state_e;

    function automatic logic [4:0] y2r_clamp_shift(input logic [4:0] s);
        if (s < Y2R_SHIFT_MIN) begin
            return Y2R_SHIFT_MIN;
        end else if (s > Y2R_SHIFT_MAX) begin
            return Y2R_SHIFT_MAX;
        end
        return s;
    endfunction

endpackage

// File: rtl/y2r_round_lut.sv
// Rounding constant / offset enable lookup for a shift value; purely combinational.
// No latency and no flow control; the caller registers the result.
module y2r_round_lut
    import y2r_pkg::*;
(
    input  logic [4:0] shift_i,
    output logic [7:0] round_num_o,
    output logic       offset_en_o
);

    always_comb begin
        round_num_o = Y2R_ROUND_RST;
        offset_en_o = 1'b1;
        case (shift_i)
            5'd8:  begin round_num_o = 8'd2;   offset_en_o = 1'b1; end
            5'd9:  begin round_num_o = 8'd5;   offset_en_o = 1'b1; end
            5'd10: begin round_num_o = 8'd1;   offset_en_o = 1'b1; end
            5'd11: begin round_num_o = 8'd2;   offset_en_o = 1'b1; end
            5'd12: begin round_num_o = 8'd4;   offset_en_o = 1'b1; end
            5'd13: begin round_num_o = 8'd8;   offset_en_o = 1'b1; end
            5'd14: begin round_num_o = 8'd16;  offset_en_o = 1'b1; end
            5'd15: begin round_num_o = 8'd33;  offset_en_o = 1'b0; end
            5'd16: begin round_num_o = 8'd66;  offset_en_o = 1'b0; end
            5'd17: begin round_num_o = 8'd131; offset_en_o = 1'b0; end
            default: begin
                round_num_o = Y2R_ROUND_RST;
                offset_en_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/y2r_para_sched.sv
// Shadow/active parameter bank for the YUV-to-RGB datapath; commits a full set on frame_start.
// Commit lands on the frame_start edge, para_upd/cfg_err pulse the following cycle;
// cfg_ready is low while a set waits for a frame. Y2R_SHIFT_CLAMP_EN clamps shift writes.
module y2r_para_sched
    import y2r_pkg::*;
#(
    parameter int PARA_DW = 12
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [3:0]               cfg_addr,
    input  logic [PARA_DW+8-1:0]     cfg_data,
    input  logic                     cfg_last,
    input  logic                     frame_start,
    output logic [9*PARA_DW-1:0]     coef_mat,
    output logic [3*(PARA_DW+8)-1:0] coef_off,
    output logic [4:0]               shift_act,
    output logic [7:0]               round_num,
    output logic                     offset_en,
    output logic                     para_upd,
    output logic                     pend,
    output logic                     cfg_err,
    output logic [7:0]               upd_cnt
);

    localparam int OFF_W = PARA_DW + 8;

    y2r_state_e state_q, state_d;

    logic [8:0][PARA_DW-1:0] sh_coef_q, sh_coef_d, act_coef_q;
    logic [2:0][OFF_W-1:0]   sh_off_q, sh_off_d, act_off_q;
    logic [4:0]              sh_shift_q, sh_shift_d, act_shift_q;
    logic [7:0]              round_q, upd_cnt_q;
    logic                    offset_en_q, para_upd_q, cfg_err_q;

    logic       wr_acc, addr_bad, shift_bad, wr_err, commit;
    logic [4:0] shift_wr;
    logic [1:0] off_idx;
    logic [7:0] lut_round;
    logic       lut_offset_en;

    assign cfg_ready = (state_q == Y2R_IDLE);
    assign pend      = (state_q == Y2R_PEND);
    assign wr_acc    = cfg_valid && cfg_ready;
    assign addr_bad  = (cfg_addr > Y2R_ADDR_SHIFT);
    assign off_idx   = 2'(cfg_addr - Y2R_ADDR_OFF0);

`ifdef Y2R_SHIFT_CLAMP_EN
    assign shift_bad = 1'b0;
    assign shift_wr  = y2r_clamp_shift(cfg_data[4:0]);
`else
    assign shift_bad = (cfg_addr == Y2R_ADDR_SHIFT) &&
                       ((cfg_data[4:0] < Y2R_SHIFT_MIN) || (cfg_data[4:0] > Y2R_SHIFT_MAX));
    assign shift_wr  = cfg_data[4:0];
`endif

    assign wr_err = addr_bad || shift_bad;

    // Rejected writes leave the shadow bank untouched.
    always_comb begin
        sh_coef_d  = sh_coef_q;
        sh_off_d   = sh_off_q;
        sh_shift_d = sh_shift_q;
        if (wr_acc && !wr_err) begin
            if (cfg_addr <= Y2R_ADDR_M22) begin
                sh_coef_d[cfg_addr] = cfg_data[PARA_DW-1:0];
            end else if (cfg_addr <= Y2R_ADDR_OFF2) begin
                sh_off_d[off_idx] = cfg_data;
            end else begin
                sh_shift_d = shift_wr;
            end
        end
    end

    // A frame_start arriving with the last write is seen in IDLE, so it never commits.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            Y2R_IDLE: begin
                if (wr_acc && cfg_last) begin
                    state_d = Y2R_PEND;
                end
            end
            Y2R_PEND: begin
                if (frame_start) begin
                    commit  = 1'b1;
                    state_d = Y2R_IDLE;
                end
            end
            default: state_d = Y2R_IDLE;
        endcase
    end

    y2r_round_lut u_round_lut (
        .shift_i     (sh_shift_q),
        .round_num_o (lut_round),
        .offset_en_o (lut_offset_en)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= Y2R_IDLE;
            sh_coef_q  <= '0;
            sh_off_q   <= '0;
            sh_shift_q <= Y2R_SHIFT_RST;
            para_upd_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_coef_q  <= sh_coef_d;
            sh_off_q   <= sh_off_d;
            sh_shift_q <= sh_shift_d;
            para_upd_q <= commit;
            cfg_err_q  <= wr_acc && wr_err;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            act_coef_q  <= '0;
            act_off_q   <= '0;
            act_shift_q <= Y2R_SHIFT_RST;
            round_q     <= Y2R_ROUND_RST;
            offset_en_q <= 1'b1;
            upd_cnt_q   <= 8'd0;
        end else if (commit) begin
            act_coef_q  <= sh_coef_q;
            act_off_q   <= sh_off_q;
            act_shift_q <= sh_shift_q;
            round_q     <= lut_round;
            offset_en_q <= lut_offset_en;
            upd_cnt_q   <= upd_cnt_q + 8'd1;
        end
    end

    assign coef_mat  = act_coef_q;
    assign coef_off  = act_off_q;
    assign shift_act = act_shift_q;
    assign round_num = round_q;
    assign offset_en = offset_en_q;
    assign para_upd  = para_upd_q;
    assign cfg_err   = cfg_err_q;
    assign upd_cnt   = upd_cnt_q;

endmodule

// File: tb/tb_y2r_para_sched.sv
// Bench for y2r_para_sched: directed vector table, reset-while-pending sequence,
// then random traffic against a set-level reference model.
module tb_y2r_para_sched;

    localparam int PDW = 12;
    localparam int OW  = PDW + 8;
`ifdef Y2R_SHIFT_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic             cfg_valid, cfg_ready, cfg_last, frame_start;
    logic [3:0]       cfg_addr;
    logic [OW-1:0]    cfg_data;
    logic [9*PDW-1:0] coef_mat;
    logic [3*OW-1:0]  coef_off;
    logic [4:0]       shift_act;
    logic [7:0]       round_num, upd_cnt;
    logic             offset_en, para_upd, pend, cfg_err;

    always #5 clk_in = ~clk_in;

    y2r_para_sched #(.PARA_DW(PDW)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_last(cfg_last), .frame_start(frame_start),
        .coef_mat(coef_mat), .coef_off(coef_off), .shift_act(shift_act),
        .round_num(round_num), .offset_en(offset_en), .para_upd(para_upd),
        .pend(pend), .cfg_err(cfg_err), .upd_cnt(upd_cnt)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: a shadow set, an active set and a "set waiting" flag.
    int lut_round [8:17] = '{2, 5, 1, 2, 4, 8, 16, 33, 66, 131};
    int lut_oen   [8:17] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    logic [PDW-1:0] m_sh_coef [9];
    logic [PDW-1:0] m_ac_coef [9];
    logic [OW-1:0]  m_sh_off [3];
    logic [OW-1:0]  m_ac_off [3];
    int m_sh_shift, m_ac_shift, m_round, m_oen, m_cnt;
    bit m_pend, m_upd, m_err;

    function automatic void model_reset();
        for (int i = 0; i < 9; i++) begin m_sh_coef[i] = '0; m_ac_coef[i] = '0; end
        for (int i = 0; i < 3; i++) begin m_sh_off[i] = '0; m_ac_off[i] = '0; end
        m_sh_shift = 8; m_ac_shift = 8; m_round = 2; m_oen = 1; m_cnt = 0;
        m_pend = 0; m_upd = 0; m_err = 0;
    endfunction

    function automatic void model_edge();
        int a;
        int sv;
        m_upd = 0;
        m_err = 0;
        a  = int'(cfg_addr);
        sv = int'(cfg_data[4:0]);
        if (!m_pend) begin
            if (cfg_valid) begin
                if (a <= 8) m_sh_coef[a] = cfg_data[PDW-1:0];
                else if (a <= 11) m_sh_off[a-9] = cfg_data;
                else if (a == 12) begin
                    if (CLAMP) m_sh_shift = (sv < 8) ? 8 : ((sv > 17) ? 17 : sv);
                    else if (sv < 8 || sv > 17) m_err = 1;
                    else m_sh_shift = sv;
                end else m_err = 1;
                if (cfg_last) m_pend = 1;
            end
        end else if (frame_start) begin
            for (int i = 0; i < 9; i++) m_ac_coef[i] = m_sh_coef[i];
            for (int i = 0; i < 3; i++) m_ac_off[i] = m_sh_off[i];
            m_ac_shift = m_sh_shift;
            m_round = lut_round[m_sh_shift];
            m_oen   = lut_oen[m_sh_shift];
            m_cnt   = (m_cnt + 1) % 256;
            m_upd   = 1;
            m_pend  = 0;
        end
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [9*PDW-1:0] ec;
        logic [3*OW-1:0]  eo;
        for (int i = 0; i < 9; i++) ec[i*PDW +: PDW] = m_ac_coef[i];
        for (int i = 0; i < 3; i++) eo[i*OW +: OW] = m_ac_off[i];
        check({tag, "_coef_mat"}, coef_mat, ec);
        check({tag, "_coef_off"}, coef_off, eo);
        check({tag, "_shift_act"}, shift_act, m_ac_shift);
        check({tag, "_round_num"}, round_num, m_round);
        check({tag, "_offset_en"}, offset_en, m_oen);
        check({tag, "_cfg_ready"}, cfg_ready, !m_pend);
        check({tag, "_pend"}, pend, m_pend);
        check({tag, "_para_upd"}, para_upd, m_upd);
        check({tag, "_cfg_err"}, cfg_err, m_err);
        check({tag, "_upd_cnt"}, upd_cnt, m_cnt);
    endtask

    task automatic step(input bit v, input logic [3:0] a, input logic [OW-1:0] d,
                        input bit l, input bit fs);
        cfg_valid = v; cfg_addr = a; cfg_data = d; cfg_last = l; frame_start = fs;
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    typedef struct {
        bit v; logic [3:0] a; logic [OW-1:0] d; bit l; bit fs;
        bit e_pend; bit e_err; bit e_upd;
        int e_shift; int e_round; int e_oen; int e_cnt; logic [PDW-1:0] e_c00;
    } vec_t;
    vec_t tbl [11];

    logic [3:0]    r_a;
    logic [OW-1:0] r_d;

    initial begin
        tbl[0]  = '{1'b1, 4'd0,  20'h12A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, 2, 1, 0, 12'h000};
        tbl[1]  = '{1'b1, 4'd12, 20'd10,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8, 2, 1, 0, 12'h000};
        tbl[2]  = '{1'b0, 4'd0,  20'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8, 2, 1, 0, 12'h000};
        tbl[3]  = '{1'b0, 4'd0,  20'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10, 1, 1, 1, 12'h12A};
        tbl[4]  = '{1'b0, 4'd0,  20'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 1, 1, 1, 12'h12A};
        tbl[5]  = '{1'b1, 4'd12, 20'd16,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10, 1, 1, 1, 12'h12A};
        tbl[6]  = '{1'b0, 4'd0,  20'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16, 66, 0, 2, 12'h12A};
        tbl[7]  = '{1'b1, 4'd14, 20'd5,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16, 66, 0, 2, 12'h12A};
        tbl[8]  = '{1'b0, 4'd0,  20'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16, 66, 0, 3, 12'h12A};
        tbl[9]  = '{1'b1, 4'd12, 20'd20,  1'b1, 1'b0, 1'b1, !CLAMP, 1'b0, 16, 66, 0, 3, 12'h12A};
        tbl[10] = '{1'b0, 4'd0,  20'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                    CLAMP ? 17 : 16, CLAMP ? 131 : 66, 0, 4, 12'h12A};

        rst_n_in = 1'b0;
        cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_last = 1'b0; frame_start = 1'b0;
        model_reset();
        #12;
        check("rst_shift_act", shift_act, 5'd8);
        check("rst_round_num", round_num, 8'd2);
        check("rst_offset_en", offset_en, 1'b1);
        check("rst_coef_mat", coef_mat, '0);
        check("rst_cfg_ready", cfg_ready, 1'b1);
        check("rst_upd_cnt", upd_cnt, 8'd0);
        check_all("rst");
        rst_n_in = 1'b1;

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].l, tbl[i].fs);
            check_all($sformatf("row%0d", i));
            check($sformatf("row%0d_pend", i), pend, tbl[i].e_pend);
            check($sformatf("row%0d_err", i), cfg_err, tbl[i].e_err);
            check($sformatf("row%0d_upd", i), para_upd, tbl[i].e_upd);
            check($sformatf("row%0d_shift", i), shift_act, tbl[i].e_shift);
            check($sformatf("row%0d_round", i), round_num, tbl[i].e_round);
            check($sformatf("row%0d_oen", i), offset_en, tbl[i].e_oen);
            check($sformatf("row%0d_cnt", i), upd_cnt, tbl[i].e_cnt);
            check($sformatf("row%0d_c00", i), coef_mat[PDW-1:0], tbl[i].e_c00);
        end

        // Reset while a set is pending discards it.
        step(1'b1, 4'd1, 20'h055, 1'b0, 1'b0);
        step(1'b1, 4'd12, 20'd12, 1'b1, 1'b0);
        check("rstp_pend_before", pend, 1'b1);
        cfg_valid = 1'b0; cfg_last = 1'b0;
        #2 rst_n_in = 1'b0;
        model_reset();
        #1;
        check("rstp_pend", pend, 1'b0);
        check("rstp_ready", cfg_ready, 1'b1);
        check_all("rstp_in_reset");
        #2 rst_n_in = 1'b1;
        step(1'b0, 4'd0, 20'd0, 1'b0, 1'b1);
        check("rstp_fs_shift", shift_act, 5'd8);
        check("rstp_fs_round", round_num, 8'd2);
        check("rstp_fs_cnt", upd_cnt, 8'd0);
        check("rstp_fs_coef", coef_mat, '0);
        check("rstp_fs_upd", para_upd, 1'b0);
        check_all("rstp_fs");

        for (int k = 0; k < 3000; k++) begin
            r_a = 4'($urandom_range(0, 15));
            r_d = OW'($urandom);
            if (r_a == 4'd12) r_d[4:0] = 5'($urandom_range(0, 31));
            step($urandom_range(0, 1) == 1, r_a, r_d, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0);
            check_all("rand");
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n_in = 1'b0;
                model_reset();
                #1;
                check_all("rand_rst");
                #2 rst_n_in = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/y2r_para_sched.md
# y2r_para_sched

Parameter scheduler for the YUV-to-RGB conversion datapath. Accepts coefficient, offset and shift writes from the configuration bus into a shadow bank. Commits a complete parameter set atomically to the active bank on the next frame boundary, so the datapath never sees a partially updated matrix mid-frame. Derives the registered `round_num`/`offset_en` pair for the active shift and sits between the register interface and the conversion pipeline.

## Interface
Parameters:
- `PARA_DW`, 12: matrix coefficient width; offset entries are `PARA_DW+8` wide.

Ports:
- `clk_in`  input  1  clock; one clock domain; reset is asynchronous and active-low.
- `rst_n_in`  input  1  asynchronous active-low reset.
- `cfg_valid`  input  1  write request.
- `cfg_ready`  output  1  scheduler can accept a write.
- `cfg_addr`  input  4  entry select (map below).
- `cfg_data`  input  `PARA_DW+8`  write data.
- `cfg_last`  input  1  qualifies the final write of a set.
- `frame_start`  input  1  single-cycle pulse at the first pixel of a frame.
- `coef_mat`  output  `9*PARA_DW`  active matrix, entry 00 in the LSBs, row-major.
- `coef_off`  output  `3*(PARA_DW+8)`  active offsets 03/13/23, 03 in the LSBs.
- `shift_act`  output  5  active shift.
- `round_num`  output  8  rounding constant for `shift_act`.
- `offset_en`  output  1  offset enable for `shift_act`.
- `para_upd`  output  1  one-cycle pulse after a commit.
- `pend`  output  1  a complete set is waiting for a frame boundary.
- `cfg_err`  output  1  one-cycle pulse on a rejected write.
- `upd_cnt`  output  8  commit counter.

## Operation
Address map:
- 0–8: matrix entries 00..22, taking `cfg_data[PARA_DW-1:0]`.
- 9–11: offsets 03, 13, 23, taking full width.
- 12: shift, taking `cfg_data[4:0]`.
- 13–15: invalid. The write is ignored and `cfg_err` pulses.

FSM states are IDLE and PEND.
- **IDLE:**
  - `cfg_ready=1`. A write happens when `cfg_valid & cfg_ready` and updates the shadow bank.
  - An accepted write with `cfg_last=1` moves the FSM to PEND, including when that write is itself an error.
  - Shadow entries not written keep their previous values.
- **PEND:**
  - `cfg_ready=0` and `pend=1`.
  - On `frame_start=1`, the shadow bank is copied to the active bank, `round_num`/`offset_en` load from the lookup of the shadow shift, `upd_cnt` increments, and the FSM returns to IDLE.

Shift lookup (shift: `round_num`/`offset_en`):
- 8: 2/1
- 9: 5/1
- 10: 1/1
- 11: 2/1
- 12: 4/1
- 13: 8/1
- 14: 16/1
- 15: 33/0
- 16: 66/0
- 17: 131/0

The stored shift is always within 8..17 (see Configuration).

Arithmetic: `upd_cnt` wraps 255→0. There is no other arithmetic.

Reset values:
- Shadow and active coefficients and offsets: 0.
- Shift (shadow and active) and `shift_act`: 8.
- `round_num`: 2. `offset_en`: 1.
- `para_upd`, `pend`, `cfg_err`: 0. `upd_cnt`: 0.
- FSM: IDLE.

## Timing
- A write accepted at edge t: the shadow bank is updated at t; `cfg_err` is high during cycle t+1 for a rejected write.
- `cfg_last` accepted at edge t: `pend=1` and `cfg_ready=0` from t+1.
- `frame_start` high in PEND at edge t: all active outputs change at t; `para_upd=1` for cycle t+1 only; `pend=0` from t+1.
- `frame_start` in the same cycle as the accepted `cfg_last`: no commit. The set commits on the next `frame_start`.
- `frame_start` in IDLE: no effect on the active bank.
- Active outputs are constant between commits.
- Reset mid-operation: asynchronous clear to reset values; any pending set is discarded.

## Configuration
`Y2R_SHIFT_CLAMP_EN`:
- Defined: shift writes below 8 store 8 and writes above 17 store 17; there is no error.
- Undefined: an out-of-range shift write is rejected. The shadow shift is unchanged and `cfg_err` pulses. `cfg_last` on that write still moves the FSM to PEND.

## Structure
Shared package `y2r_pkg`:
- Address constants `Y2R_ADDR_M00`..`Y2R_ADDR_SHIFT`.
- `Y2R_SHIFT_MIN=8`, `Y2R_SHIFT_MAX=17`.
- Reset shift constant.
- FSM state enum.

One combinational sub-module, `y2r_round_lut`: shift in; `round_num`, `offset_en` out. The top registers its outputs at commit.

## Test plan
- Reset → `shift_act=8`, `round_num=2`, `offset_en=1`, `coef_mat=0`, `cfg_ready=1`, `upd_cnt=0`.
- Write addr 0 = 0x12A, addr 12 = 10 with `cfg_last` → `pend=1`, outputs unchanged. `frame_start` → `coef_mat[11:0]=0x12A`, `shift_act=10`, `round_num=1`, `offset_en=1`, one `para_upd` pulse, `upd_cnt=1`.
- Shift 16 with `cfg_last` in the same cycle as `frame_start` → no commit. Next `frame_start` → `round_num=66`, `offset_en=0`.
- Write to addr 14 → `cfg_err` pulse; shadow unchanged; after commit, outputs match the prior set.
- Shift write of 20:
  - With the macro: `shift_act=17`, `round_num=131`.
  - Without the macro: `cfg_err` pulse, `shift_act` keeps its previous value.
- Assert `rst_n_in` while PEND → `pend=0`, IDLE; a later `frame_start` leaves reset values unchanged.
